// File: rtl/ha_mul_pkg.sv
// Shared constants and the row-weighting function for the 8x8 approximate
// multiplier's half-adder array and its reduction pipeline.
package ha_mul_pkg;

  localparam int N_ARR = 4;
  localparam int T_W   = 9;
  localparam int B_W   = 7;
  localparam int P_W   = 16;

  // Bottom rows sit two columns above their top-row partner.
  localparam int B_OFS = 2;

  function automatic int row_base(input int k);
    return 2 * k;
  endfunction

  // A_k: top row rooted at column 2k, bottom row at 2k+2, truncated to P_W bits.
  function automatic logic [P_W-1:0] row_weight(input logic [T_W-1:0] t,
                                                input logic [B_W-1:0] b,
                                                input int k);
    logic [P_W-1:0] tw;
    logic [P_W-1:0] bw;
    tw = P_W'(t) << row_base(k);
    bw = P_W'(b) << (row_base(k) + B_OFS);
    return tw + bw;
  endfunction

endpackage

// File: rtl/ha_row_weight.sv
// Combinational column weighting of one ha_array top/bottom row pair.
module ha_row_weight
  import ha_mul_pkg::*;
#(
  parameter int K = 0
) (
  input  logic [T_W-1:0] t,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] a
);

  assign a = row_weight(t, b, K);

endmodule

// File: rtl/ha_array_reduce_pipe.sv
// Two-stage valid/ready pipeline that accumulates the four weighted ha_array
// row pairs into the 16-bit product.
module ha_array_reduce_pipe
  import ha_mul_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [T_W-1:0] ha_array_0_t,
  input  logic [T_W-1:0] ha_array_1_t,
  input  logic [T_W-1:0] ha_array_2_t,
  input  logic [T_W-1:0] ha_array_3_t,
  input  logic [B_W-1:0] ha_array_0_b,
  input  logic [B_W-1:0] ha_array_1_b,
  input  logic [B_W-1:0] ha_array_2_b,
  input  logic [B_W-1:0] ha_array_3_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] out_prod
);

  // Handshake: a beat moves on a port only in a cycle where valid && ready
  // are both high at the clock edge; valid never depends on ready, and data
  // is held stable while valid is high and ready is low.

  logic [T_W-1:0] t_arr [N_ARR];
  logic [B_W-1:0] b_arr [N_ARR];
  logic [P_W-1:0] a_row [N_ARR];

  assign t_arr[0] = ha_array_0_t;
  assign t_arr[1] = ha_array_1_t;
  assign t_arr[2] = ha_array_2_t;
  assign t_arr[3] = ha_array_3_t;
  assign b_arr[0] = ha_array_0_b;
  assign b_arr[1] = ha_array_1_b;
  assign b_arr[2] = ha_array_2_b;
  assign b_arr[3] = ha_array_3_b;

  for (genvar k = 0; k < N_ARR; k++) begin : g_row
    ha_row_weight #(.K(k)) u_row (
      .t (t_arr[k]),
      .b (b_arr[k]),
      .a (a_row[k])
    );
  end

  logic           v1;
  logic           v2;
  logic [P_W-1:0] s01;
  logic [P_W-1:0] s23;
  logic           adv2;
  logic           accept;

  // No skid buffer: in_ready is combinational from out_ready.
  assign adv2      = !v2 || out_ready;
  assign in_ready  = !v1 || adv2;
  assign accept    = in_valid && in_ready;
  assign out_valid = v2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      s01      <= '0;
      s23      <= '0;
      out_prod <= '0;
    end else begin
      if (accept) begin
        s01 <= a_row[0] + a_row[1];
        s23 <= a_row[2] + a_row[3];
      end
      if (accept)    v1 <= 1'b1;
      else if (adv2) v1 <= 1'b0;

      if (adv2) begin
        v2 <= v1 ? 1'b1 : (out_ready ? 1'b0 : v2);
        if (v1) out_prod <= s01 + s23;
      end
    end
  end

endmodule

// File: tb/tb_ha_array_reduce_pipe.sv
// Directed self-checking bench for ha_array_reduce_pipe: latency, weighting,
// backpressure, alternating ready and mid-operation reset.
module tb_ha_array_reduce_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  t0 = '0, t1 = '0, t2 = '0, t3 = '0;
  logic [6:0]  b0 = '0, b1 = '0, b2 = '0, b3 = '0;
  logic        out_valid;
  logic        out_ready;
  logic        out_ready_m = 1'b1;
  logic        alt_en = 1'b0;
  logic        alt_r = 1'b0;
  logic [15:0] out_prod;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  // Vector table: {t3,t2,t1,t0}, {b3,b2,b1,b0}, hand-computed product.
  logic [35:0] tab_t [10];
  logic [27:0] tab_b [10];
  logic [15:0] tab_e [10];

  assign out_ready = alt_en ? alt_r : out_ready_m;

  ha_array_reduce_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_t (t0),
    .ha_array_1_t (t1),
    .ha_array_2_t (t2),
    .ha_array_3_t (t3),
    .ha_array_0_b (b0),
    .ha_array_1_b (b1),
    .ha_array_2_b (b2),
    .ha_array_3_b (b3),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_prod     (out_prod)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    alt_r = ~alt_r;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input int v);
    {t3, t2, t1, t0} = tab_t[v];
    {b3, b2, b1, b0} = tab_b[v];
  endtask

  // Called just after a posedge; returns just after the accepting edge.
  task automatic send(input int v);
    logic ok;
    set_beat(v);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (ok) exp_q.push_back(tab_e[v]);
    else    check("send_timeout", {15'b0, in_ready}, 16'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) check("drain_timeout", 16'(exp_q.size()), 16'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every transferred product must match the head of exp_q.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", {15'b0, out_valid}, 16'd0);
      else                   check("prod", out_prod, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tab_t[0] = 36'h0;                    tab_b[0] = 28'h0;          tab_e[0] = 16'h0000;
    tab_t[1] = {9'h0, 9'h0, 9'h0, 9'h001}; tab_b[1] = 28'h0;        tab_e[1] = 16'h0001;
    tab_t[2] = {9'h001, 9'h0, 9'h0, 9'h0}; tab_b[2] = 28'h0;        tab_e[2] = 16'h0040;
    tab_t[3] = 36'h0; tab_b[3] = {7'h40, 7'h0, 7'h0, 7'h0};         tab_e[3] = 16'h4000;
    // x=3, y=5 through the half-adder front end
    tab_t[4] = {9'h0, 9'h0, 9'h003, 9'h003}; tab_b[4] = 28'h0;      tab_e[4] = 16'h000F;
    // x=y=0xFF: every pair is t=0x101, b=0x7F
    tab_t[5] = {4{9'h101}}; tab_b[5] = {4{7'h7F}};                  tab_e[5] = 16'hFE01;
    // Sum past 0xFFFF wraps
    tab_t[6] = {9'h1FF, 9'h1FF, 9'h0, 9'h0};
    tab_b[6] = {7'h7F, 7'h7F, 7'h0, 7'h0};                          tab_e[6] = 16'h3E70;
    tab_t[7] = {9'h0, 9'h0, 9'h100, 9'h0}; tab_b[7] = {7'h0, 7'h0, 7'h0, 7'h01}; tab_e[7] = 16'h0404;
    tab_t[8] = {9'h0, 9'h0, 9'h0, 9'h1FF}; tab_b[8] = {7'h0, 7'h0, 7'h0, 7'h7F}; tab_e[8] = 16'h03FB;
    tab_t[9] = {9'h0, 9'h0AA, 9'h0, 9'h0}; tab_b[9] = {7'h0, 7'h0, 7'h55, 7'h0}; tab_e[9] = 16'h0FF0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and two-cycle latency with zero arrays.
    set_beat(0);
    in_valid = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {15'b0, out_valid}, 16'd0);
    check("rst_out_prod", out_prod, 16'h0000);
    check("rst_in_ready", {15'b0, in_ready}, 16'd1);
    @(posedge clk); #1; exp_q.push_back(16'h0000);
    @(negedge clk);
    check("lat_1cyc", {15'b0, out_valid}, 16'd0);
    @(posedge clk); #1; exp_q.push_back(16'h0000);
    @(negedge clk);
    check("lat_2cyc", {15'b0, out_valid}, 16'd1);
    @(posedge clk); #1; exp_q.push_back(16'h0000);
    in_valid = 1'b0;
    @(negedge clk);
    check("tput", {15'b0, out_valid}, 16'd1);
    drain();

    // Single-row weighting and front-end cases at full rate.
    for (int v = 1; v <= 5; v++) send(v);
    in_valid = 1'b0;
    drain();

    // Backpressure: two beats fill the pipe, the third stalls.
    out_ready_m = 1'b0;
    send(6);
    send(7);
    set_beat(8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", {15'b0, in_ready}, 16'd0);
      check("stall_out_valid", {15'b0, out_valid}, 16'd1);
      check("stall_out_prod", out_prod, tab_e[6]);
      @(posedge clk); #1;
      set_beat(i + 1);
    end
    out_ready_m = 1'b1;
    send(8);
    in_valid = 1'b0;
    drain();

    // Alternating out_ready with continuous in_valid.
    alt_en = 1'b1;
    for (int v = 1; v <= 9; v++) send(v);
    in_valid = 1'b0;
    drain();
    alt_en = 1'b0;

    // Reset with both stages full drops the in-flight beats.
    out_ready_m = 1'b0;
    send(4);
    send(5);
    in_valid = 1'b0;
    @(negedge clk);
    check("full_in_ready", {15'b0, in_ready}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_out_valid", {15'b0, out_valid}, 16'd0);
    check("mid_rst_out_prod", out_prod, 16'h0000);
    check("mid_rst_in_ready", {15'b0, in_ready}, 16'd1);
    @(posedge clk); #1;
    out_ready_m = 1'b1;
    send(6);
    send(9);
    in_valid = 1'b0;
    drain();
    check("final_idle", {15'b0, out_valid}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
